// File: rtl/cpu_ctrl.sv
// Instruction sequencer: fetch/decode/execute/write-back control for a small
// 16-bit register machine, with sticky halt and illegal-opcode reporting.
module cpu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_in,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        ir_load,
  output logic        pc_inc,
  output logic [3:0]  dest_reg,
  output logic [3:0]  sour_reg,
  output logic        en_reg_mux,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      st;
  logic [15:0] ir;
  logic        halt_q;
  logic [3:0]  opcode;
  logic        op_alu;
  logic        op_undef;
  logic        ir_unused;

  assign opcode    = ir[15:12];
  assign op_alu    = (opcode >= 4'd1) && (opcode <= 4'd6);
  assign op_undef  = (opcode >= 4'd7) && (opcode <= 4'd14);
  assign ir_unused = ^ir[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= FETCH;
      ir     <= 16'd0;
      halt_q <= 1'b0;
    end else begin
      case (st)
        FETCH: begin
          // Once halted, the machine parks here and ignores memory.
          if (!halt_q && mem_ready) begin
            ir <= ir_in;
            st <= DECODE;
          end
        end
        DECODE: begin
          if (op_alu) begin
            st <= EXEC;
          end else begin
            if (opcode == 4'hF) halt_q <= 1'b1;
            st <= FETCH;
          end
        end
        EXEC:    st <= WB;
        default: st <= FETCH;
      endcase
    end
  end

  // Outputs are decoded from the registered state; ir_load/pc_inc follow
  // mem_ready in the same cycle, and reset forces every output low.
  always_comb begin
    mem_rd     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    en_reg_mux = 1'b0;
    alu_op     = 3'd0;
    illegal    = 1'b0;
    dest_reg   = 4'd0;
    sour_reg   = 4'd0;
    halted     = 1'b0;
    state      = 2'd0;
    if (!rst) begin
      dest_reg = ir[11:8];
      sour_reg = ir[7:4];
      halted   = halt_q;
      state    = st;
      case (st)
        FETCH: begin
          if (!halt_q) begin
            mem_rd = 1'b1;
            if (mem_ready) begin
              ir_load = 1'b1;
              pc_inc  = 1'b1;
            end
          end
        end
        DECODE: illegal = op_undef;
        EXEC:   alu_op  = ir[14:12];
        default: begin
          alu_op     = ir[14:12];
          en_reg_mux = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed vector table, multi-cycle corner sequences and
// a randomized run against an instruction-timeline reference model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir_in = 16'd0;
  logic        mem_ready = 1'b0;
  logic        mem_rd, ir_load, pc_inc, en_reg_mux, halted, illegal;
  logic [3:0]  dest_reg, sour_reg;
  logic [2:0]  alu_op;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  cpu_ctrl dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .ir_load(ir_load), .pc_inc(pc_inc),
    .dest_reg(dest_reg), .sour_reg(sour_reg), .en_reg_mux(en_reg_mux),
    .alu_op(alu_op), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        rdy;
    logic [15:0] ir;
    logic [1:0]  st;
    logic        rd, ld, en, ill, hlt;
    logic [2:0]  alu;
    logic [3:0]  dst, src;
  } vec_t;

  function automatic logic [31:0] pk(input logic [1:0] st, input logic rd, ld, pc, en, ill, h,
                                     input logic [2:0] alu, input logic [3:0] dst, src);
    return {10'd0, st, rd, ld, pc, en, ill, h, alu, dst, src};
  endfunction

  function automatic logic [31:0] obs();
    return pk(state, mem_rd, ir_load, pc_inc, en_reg_mux, illegal, halted, alu_op, dest_reg, sour_reg);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic rdy, input logic [15:0] ir);
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = rdy;
    ir_in = ir;
    @(negedge clk);
  endtask

  // Reference model: position within the current instruction's timeline.
  int          m_pos;
  logic [15:0] m_ir;
  logic        m_halt;

  function automatic int ins_len(input logic [3:0] op);
    return (op >= 1 && op <= 6) ? 4 : 2;
  endfunction

  function automatic logic [31:0] model_exp(input logic r, input logic rdy);
    logic [3:0] op;
    logic rd, ld;
    op = m_ir[15:12];
    if (r) return 32'd0;
    rd = (m_pos == 0) && !m_halt;
    ld = rd && rdy;
    return pk(m_pos[1:0], rd, ld, ld, m_pos == 3, (m_pos == 1) && op >= 7 && op <= 14,
              m_halt, (m_pos >= 2) ? op[2:0] : 3'd0, m_ir[11:8], m_ir[7:4]);
  endfunction

  task automatic model_step(input logic r, input logic rdy, input logic [15:0] ir);
    logic [3:0] op;
    op = m_ir[15:12];
    if (r) begin
      m_pos = 0; m_ir = 16'd0; m_halt = 1'b0;
    end else if (m_pos == 0) begin
      if (!m_halt && rdy) begin
        m_ir = ir; m_pos = 1;
      end
    end else begin
      if (m_pos == 1 && op == 4'hF) m_halt = 1'b1;
      m_pos = (m_pos + 1 == ins_len(op)) ? 0 : m_pos + 1;
    end
  endtask

  vec_t tbl[14];

  initial begin
    int cnt, seen, loads;
    logic r, rdy;
    logic [15:0] ir;
    logic [3:0] op;

    tbl[0]  = '{1'b1, 1'b1, 16'h2350, 2'd0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h2350, 2'd0, 1, 1, 0, 0, 0, 3'd0, 4'd0, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 2'd1, 0, 0, 0, 0, 0, 3'd0, 4'd3, 4'd5};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 2'd2, 0, 0, 0, 0, 0, 3'd2, 4'd3, 4'd5};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 2'd3, 0, 0, 1, 0, 0, 3'd2, 4'd3, 4'd5};
    tbl[5]  = '{1'b0, 1'b1, 16'h0000, 2'd0, 1, 1, 0, 0, 0, 3'd0, 4'd3, 4'd5};
    tbl[6]  = '{1'b0, 1'b1, 16'h6770, 2'd1, 0, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0};
    tbl[7]  = '{1'b0, 1'b1, 16'h6770, 2'd0, 1, 1, 0, 0, 0, 3'd0, 4'd0, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 2'd1, 0, 0, 0, 0, 0, 3'd0, 4'd7, 4'd7};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 2'd2, 0, 0, 0, 0, 0, 3'd6, 4'd7, 4'd7};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 2'd3, 0, 0, 1, 0, 0, 3'd6, 4'd7, 4'd7};
    tbl[11] = '{1'b0, 1'b1, 16'h9000, 2'd0, 1, 1, 0, 0, 0, 3'd0, 4'd7, 4'd7};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 2'd1, 0, 0, 0, 1, 0, 3'd0, 4'd0, 4'd0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 2'd0, 1, 0, 0, 0, 0, 3'd0, 4'd0, 4'd0};

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].rdy, tbl[i].ir);
      chk($sformatf("vec%0d", i), obs(),
          pk(tbl[i].st, tbl[i].rd, tbl[i].ld, tbl[i].ld, tbl[i].en, tbl[i].ill, tbl[i].hlt,
             tbl[i].alu, tbl[i].dst, tbl[i].src));
    end

    // Slow memory: three wait cycles, then a MOV.
    cyc(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      chk("wait_rd_ld", {30'd0, mem_rd, ir_load}, 32'd2);
    end
    cyc(1'b0, 1'b1, 16'h1120);
    chk("mov_load", {30'd0, mem_rd, ir_load}, 32'd3);
    cnt = 0; seen = 0; loads = 0;
    for (int i = 1; i <= 6 && seen == 0; i++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      loads += ir_load;
      if (en_reg_mux) begin
        seen = i;
        chk("mov_dest", {28'd0, dest_reg}, 32'd1);
      end
    end
    chk("mov_wb_delay", seen, 3);
    chk("mov_extra_loads", loads, 0);

    // Halt: sticky against a ready memory, cleared only by reset.
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'hF000);
    chk("hlt_load", {31'd0, ir_load}, 32'd1);
    cyc(1'b0, 1'b1, 16'hF000);
    chk("hlt_decode", {30'd0, state}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 16'h2350);
      if (!halted || mem_rd || ir_load || pc_inc || en_reg_mux) cnt++;
    end
    chk("halted_quiet_cycles", cnt, 0);
    cyc(1'b1, 1'b1, 16'h2350);
    chk("rst_in_halt", obs(), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("halt_cleared", {30'd0, halted, mem_rd}, 32'd1);

    // Reset during EXEC abandons the write-back.
    cyc(1'b0, 1'b1, 16'h4120);
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("and_exec", {27'd0, state, alu_op}, {27'd0, 2'd2, 3'd4});
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rst_mid_exec", obs(), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("resume_fetch", {29'd0, state, mem_rd}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      cnt += en_reg_mux;
    end
    chk("no_wb_after_rst", cnt, 0);

    // Randomized run against the reference model.
    cyc(1'b1, 1'b0, 16'h0000);
    model_step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 60);
      op  = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
      ir  = {op, 12'($urandom)};
      cyc(r, rdy, ir);
      chk($sformatf("rand%0d", i), obs(), model_exp(r, rdy));
      model_step(r, rdy, ir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 clk  input  1  rising-edge system clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 ir_in  input  16  instruction word from memory; valid when mem_ready=1.
REQ-004 mem_ready  input  1  memory handshake; instruction word valid this cycle.
REQ-005 mem_rd  output  1  instruction fetch request.
REQ-006 ir_load  output  1  one-cycle pulse; instruction register captures ir_in.
REQ-007 pc_inc  output  1  one-cycle pulse; program counter advances.
REQ-008 dest_reg  output  4  destination register index, drives the register-select stage.
REQ-009 sour_reg  output  4  source register index, drives the register-select stage.
REQ-010 en_reg_mux  output  1  register write-enable gate; high for the single write-back cycle only.
REQ-011 alu_op  output  3  ALU operation code.
REQ-012 halted  output  1  sticky halt indicator.
REQ-013 illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-014 state  output  2  current FSM state, for debug.

Function
REQ-015 The internal IR (16 bits) SHALL hold the instruction as: [15:12] opcode, [11:8] dest, [7:4] source, [3:0] ignored.
REQ-016 Opcodes: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOT, F HLT; opcodes 7-E are undefined.
REQ-017 The FSM SHALL have four states: FETCH=0, DECODE=1, EXEC=2, WB=3; halt is held by the halted flag with state=FETCH.
REQ-018 FETCH: mem_rd=1 while halted=0.
- mem_ready=0 -> remain in FETCH with no other change.
- mem_ready=1 -> ir_load=1, pc_inc=1 for that cycle, IR<=ir_in, next state DECODE.
REQ-019 DECODE, opcode 0 -> FETCH; no write-back.
REQ-020 DECODE, opcode 7-E -> illegal=1 for that cycle, next state FETCH; no write-back.
REQ-021 DECODE, opcode F -> halted<=1, next state FETCH.
REQ-022 DECODE, opcode 1-6 -> EXEC.
REQ-023 EXEC lasts exactly one cycle; alu_op=opcode[2:0] (MOV=1 pass-source ... NOT=6); next state WB.
REQ-024 WB lasts exactly one cycle; en_reg_mux=1, alu_op held; next state FETCH.
REQ-025 dest_reg=IR[11:8] and sour_reg=IR[7:4] at all times, stable from DECODE through WB.
REQ-026 alu_op=0 in every state except EXEC and WB.
REQ-027 While halted=1: mem_rd=0, ir_load=0, pc_inc=0, en_reg_mux=0; mem_ready is ignored; only rst clears halted.
REQ-028 Latency with mem_ready=1 on the first FETCH cycle: ALU instruction = 4 cycles; NOP/illegal/HLT = 2 cycles.
REQ-029 en_reg_mux, ir_load, pc_inc and illegal SHALL each be high for at most one cycle per instruction.

Reset
REQ-030 While rst=1 at a clock edge: state<=FETCH, IR<=0, halted<=0.
REQ-031 While rst=1, every output except state SHALL be 0, including mem_rd; state reads 0.
REQ-032 rst asserted mid-instruction (any state) SHALL abandon the instruction with no en_reg_mux pulse afterwards; fetch resumes on the first cycle after rst deasserts.
REQ-033 rst has priority over mem_ready and over every FSM transition.

Verification
REQ-034 Reset then ir_in=16'h2350, mem_ready=1 -> ir_load/pc_inc pulse in cycle 1; DECODE, then EXEC with alu_op=2; WB with en_reg_mux=1, dest_reg=3, sour_reg=5; FETCH in cycle 5.
REQ-035 mem_ready held 0 for 3 cycles, then 1 with ir_in=16'h1120 -> mem_rd high for 4 cycles, a single ir_load, en_reg_mux pulse 3 cycles later with dest_reg=1.
REQ-036 ir_in=16'h9000 -> illegal=1 in DECODE, no en_reg_mux, back to FETCH the next cycle.
REQ-037 ir_in=16'hF000, then mem_ready held 1 for 10 cycles -> halted=1 from the cycle after DECODE; mem_rd=0 and no further ir_load; rst clears halted=0.
REQ-038 rst pulsed during EXEC of 16'h4120 -> no en_reg_mux pulse; the cycle after rst deasserts, state=0 and mem_rd=1.
REQ-039 Back-to-back 16'h0000 then 16'h6770 -> NOP completes in 2 cycles; NOT completes 4 cycles later with alu_op=6, dest_reg=7.
